// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile sequencer.
//   SYS_N / SYS_DATA_W / SYS_ADDR_W : default array size, lane width, operand address width
//   state_e                         : sequencer states
//   FLUSH_LEN                       : wavefront drain length for the default array size
package systolic_pkg;

    localparam int unsigned SYS_N      = 4;
    localparam int unsigned SYS_DATA_W = 8;
    localparam int unsigned SYS_ADDR_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        FLUSH  = 3'd3,
        UNLOAD = 3'd4,
        DONE   = 3'd5
    } state_e;

    // Drain time: 1 memory latency + 2(N-1) skew/propagation + 1 MAC register.
    function automatic int unsigned flush_len(input int unsigned n);
        return 2 * n;
    endfunction

    localparam int unsigned FLUSH_LEN = 2 * SYS_N;

endpackage

// File: rtl/systolic_tile_ctrl.sv
// Sequencer for one output-stationary N x N systolic matrix multiply C = A * B.
// Clears the accumulators, streams K operand addresses, drains the skewed
// wavefront, then presents the N result rows over a valid/ready handshake.
// Optional feature macro: SYSTOLIC_PERF_CNT_EN adds perf_cycles (busy cycles
// of the last completed operation, saturating).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, k_len      : command pulse and reduction length K (1..2**ADDR_W)
//   busy, done, err   : status; done/err are one-cycle pulses
//   mem_rd_en/addr    : operand read strobe and address k (A column k, B row k)
//   feed_valid        : read strobe delayed by the memory latency
//   pe_clear, pe_en   : accumulator clear and array shift/MAC enable
//   out_valid/ready   : result row handshake; out_row selects the array row
module systolic_tile_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N      = SYS_N,
    parameter int unsigned DATA_W = SYS_DATA_W,
    parameter int unsigned ADDR_W = SYS_ADDR_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDR_W:0]                       k_len,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err,
    output logic                                  mem_rd_en,
    output logic [ADDR_W-1:0]                     mem_rd_addr,
    output logic                                  feed_valid,
    output logic                                  pe_clear,
    output logic                                  pe_en,
    output logic                                  out_valid,
`ifdef SYSTOLIC_PERF_CNT_EN
    output logic [31:0]                           perf_cycles,
`endif
    input  logic                                  out_ready,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  out_row
);

    localparam int unsigned ROW_W    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned FL_CYC   = flush_len(N);
    localparam int unsigned FL_W     = (FL_CYC > 1) ? $clog2(FL_CYC) : 1;

    state_e             state_q, state_d;
    logic [ADDR_W:0]    k_q, k_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [FL_W-1:0]    flush_q, flush_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               err_q, err_d;
    logic               busy_q, done_q, pe_clear_q, pe_en_q;
    logic               mem_rd_en_q, feed_valid_q, out_valid_q;

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        flush_d = flush_q;
        row_d   = row_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (k_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = CLEAR;
                        k_d     = k_len;
                    end
                end
            end
            CLEAR: begin
                state_d = FEED;
                addr_d  = '0;
            end
            FEED: begin
                // Compare one bit wider so K = 2**ADDR_W ends on all-ones, not on wrap.
                if ({1'b0, addr_q} == k_q - (ADDR_W+1)'(1)) begin
                    state_d = FLUSH;
                    addr_d  = '0;
                    flush_d = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            FLUSH: begin
                if (flush_q == FL_W'(FL_CYC - 1)) begin
                    state_d = UNLOAD;
                    flush_d = '0;
                    row_d   = '0;
                end else begin
                    flush_d = flush_q + FL_W'(1);
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    if (row_q == ROW_W'(N - 1)) begin
                        state_d = DONE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and outputs; outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            addr_q       <= '0;
            flush_q      <= '0;
            row_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pe_clear_q   <= 1'b0;
            pe_en_q      <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            feed_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            addr_q       <= addr_d;
            flush_q      <= flush_d;
            row_q        <= row_d;
            err_q        <= err_d;
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            pe_clear_q   <= (state_d == CLEAR);
            pe_en_q      <= (state_d == FEED) || (state_d == FLUSH);
            mem_rd_en_q  <= (state_d == FEED);
            feed_valid_q <= mem_rd_en_q;
            out_valid_q  <= (state_d == UNLOAD);
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = addr_q;
    assign feed_valid  = feed_valid_q;
    assign pe_clear    = pe_clear_q;
    assign pe_en       = pe_en_q;
    assign out_valid   = out_valid_q;
    assign out_row     = row_q;

`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0] run_q, run_d, perf_q, perf_d;

    // run counts busy cycles of the current operation up to and including this one.
    always_comb begin
        run_d  = run_q;
        perf_d = perf_q;
        if (state_q == IDLE && state_d == CLEAR) begin
            run_d = 32'd1;
        end else if (state_q != IDLE && state_d != IDLE && run_q != '1) begin
            run_d = run_q + 32'd1;
        end
        if (state_d == DONE) begin
            perf_d = run_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= '0;
            perf_q <= '0;
        end else begin
            run_q  <= run_d;
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Self-checking bench for systolic_tile_ctrl: a cycle-offset model of one
// operation is compared against the DUT on every falling edge, with directed
// cases pinning absolute latencies and randomized operations on top.
module tb_systolic_tile_ctrl;

    localparam int unsigned N      = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   k_len;
    logic              busy, done, err, mem_rd_en, feed_valid;
    logic              pe_clear, pe_en, out_valid, out_ready;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [1:0]        out_row;
`ifdef SYSTOLIC_PERF_CNT_EN
    logic [31:0]       perf_cycles;
`endif

    systolic_tile_ctrl #(.N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .feed_valid  (feed_valid),
        .pe_clear    (pe_clear),
        .pe_en       (pe_en),
        .out_valid   (out_valid),
`ifdef SYSTOLIC_PERF_CNT_EN
        .perf_cycles (perf_cycles),
`endif
        .out_ready   (out_ready),
        .out_row     (out_row)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Model: an operation is described by its cycle offset d (1 = clear cycle),
    // its K, and the number of result rows accepted so far.
    bit m_active = 1'b0;
    bit m_err_next = 1'b0;
    int m_d = 0, m_k = 0, m_rows = 0;
    int done_count = 0, last_done_cyc = 0, err_count = 0, last_err_cyc = 0;
    bit e_busy, e_done, e_err, e_clr, e_en, e_rd, e_fv, e_ov;
    int e_first_unload;

    always @(negedge clk) begin
        e_busy = 0; e_done = 0; e_clr = 0; e_en = 0; e_rd = 0; e_fv = 0; e_ov = 0;
        e_err = rst ? 1'b0 : m_err_next;
        if (!rst && m_active) begin
            e_first_unload = m_k + 2 * N + 2;
            e_busy = 1;
            e_clr  = (m_d == 1);
            e_rd   = (m_d >= 2) && (m_d <= m_k + 1);
            e_fv   = (m_d >= 3) && (m_d <= m_k + 2);
            e_en   = (m_d >= 2) && (m_d <= m_k + 1 + 2 * N);
            e_ov   = (m_d >= e_first_unload) && (m_rows < N);
            e_done = (m_rows == N);
        end
        chk("busy",       32'(busy),       32'(e_busy));
        chk("done",       32'(done),       32'(e_done));
        chk("err",        32'(err),        32'(e_err));
        chk("pe_clear",   32'(pe_clear),   32'(e_clr));
        chk("pe_en",      32'(pe_en),      32'(e_en));
        chk("mem_rd_en",  32'(mem_rd_en),  32'(e_rd));
        chk("feed_valid", 32'(feed_valid), 32'(e_fv));
        chk("out_valid",  32'(out_valid),  32'(e_ov));
        if (e_rd) chk("mem_rd_addr", 32'(mem_rd_addr), 32'(m_d - 2));
        if (e_ov) chk("out_row", 32'(out_row), 32'(m_rows));
`ifdef SYSTOLIC_PERF_CNT_EN
        if (e_done) chk("perf_cycles", perf_cycles, 32'(m_d));
`endif
        if (done === 1'b1) begin done_count++; last_done_cyc = cyc; end
        if (err === 1'b1) begin err_count++; last_err_cyc = cyc; end

        // Advance the model using the inputs the next rising edge will sample.
        if (rst) begin
            m_active   = 0;
            m_err_next = 0;
        end else begin
            m_err_next = 0;
            if (m_active) begin
                if (e_ov && out_ready) m_rows++;
                if (e_done) m_active = 0;
                else m_d++;
            end else if (start) begin
                if (k_len == '0) begin
                    m_err_next = 1;
                end else begin
                    m_active = 1;
                    m_d      = 1;
                    m_k      = int'(k_len);
                    m_rows   = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low at offsets 16..18.
    task automatic run_op(input int k, input int mode, input bit spurious, input int exp_lat);
        int  s, dc0, off;
        bit  finished;
        tick();
        start = 1'b1;
        k_len = 9'(k);
        out_ready = 1'b1;
        s   = cyc;
        dc0 = done_count;
        finished = 0;
        for (int i = 1; i < 2000 && !finished; i++) begin
            tick();
            off   = cyc - s;
            start = 1'b0;
            if (spurious && (off == 4 || off == k + 2 * N + 3)) begin
                start = 1'b1;
                k_len = 9'($urandom_range(0, 20));
            end
            case (mode)
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = !(off >= 16 && off <= 18);
                default: out_ready = 1'b1;
            endcase
            if (done_count != dc0) finished = 1;
        end
        start = 1'b0;
        chk("op_terminates", 32'(finished), 32'd1);
        if (exp_lat >= 0) chk("done_latency", 32'(last_done_cyc - s), 32'(exp_lat));
        tick();
        tick();
        chk("one_done_pulse", 32'(done_count - dc0), 32'd1);
    endtask

    task automatic err_op();
        int s, e0, d0;
        tick();
        start = 1'b1;
        k_len = '0;
        s  = cyc;
        e0 = err_count;
        d0 = done_count;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("err_pulse_count", 32'(err_count - e0), 32'd1);
        chk("err_latency", 32'(last_err_cyc - s), 32'd1);
        chk("err_no_done", 32'(done_count - d0), 32'd0);
    endtask

    task automatic reset_mid_feed();
        int s;
        tick();
        start = 1'b1;
        k_len = 9'd10;
        s = cyc;
        tick();
        start = 1'b0;
        while (cyc - s < 7) tick();
        chk("addr_before_rst", 32'(mem_rd_addr), 32'd5);
        rst = 1'b1;
        #1;
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_pe_en",     32'(pe_en),     32'd0);
        chk("rst_addr",      32'(mem_rd_addr), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        run_op(2, 0, 1'b0, 16);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        k_len = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_row",   32'(out_row),   32'd0);

        run_op(1, 0, 1'b0, 15);
        run_op(256, 0, 1'b0, 270);
        err_op();
        run_op(4, 2, 1'b0, 21);
        reset_mid_feed();
        run_op(6, 0, 1'b1, 20);

        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 4) == 0) err_op();
            run_op($urandom_range(1, 24), 1, 1'($urandom_range(0, 1)), -1);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_tile_ctrl.md
Name: systolic_tile_ctrl

Overview:
Sequencer for one output-stationary N×N systolic matrix multiply: C[N×N] = A[N×K] · B[K×N].
Issues operand-memory reads whose data feeds the row/column skew buffers, clears and enables the PE accumulators, and flushes the skewed wavefront through the array.
Then hands the N result rows to a downstream consumer over a valid/ready handshake.
Sits between the host command interface and the array/skew-buffer datapath.

Parameters:
N, 4, array dimension (rows = columns = N); also the number of lanes per skew buffer
DATA_W, 8, operand lane width; passed through only for the result row width
ADDR_W, 8, operand memory address width; K_MAX = 2**ADDR_W

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle command pulse
k_len  in  ADDR_W+1  reduction length K, legal range 1..2**ADDR_W; sampled on an accepted start
busy  out  1  high from the cycle after an accepted start through the DONE cycle
done  out  1  one-cycle pulse at the end of an operation
err  out  1  one-cycle pulse when start arrives with k_len==0 while idle
mem_rd_en  out  1  read strobe, shared by the A and B operand memories (1-cycle read latency)
mem_rd_addr  out  ADDR_W  read address k; the same address is used for A column k and B row k
feed_valid  out  1  mem_rd_en delayed one cycle; datapath forces skew-buffer raw inputs to 0 when low
pe_clear  out  1  one-cycle accumulator clear
pe_en  out  1  array shift/MAC enable
out_valid  out  1  result row available
out_ready  in  1  consumer accepts the row
out_row  out  clog2(N)  index of the result row being presented (selects the array row mux)

Behaviour:
- Reset values: all outputs 0; state = IDLE; counters = 0. Reset mid-operation aborts immediately. Operand memories and PE contents are not touched.
- States:
  - IDLE: start && k_len!=0 → CLEAR, latch K. start && k_len==0 → stay in IDLE, err=1 for one cycle.
  - CLEAR: pe_clear=1 for exactly one cycle → FEED.
  - FEED: mem_rd_en=1 each cycle; mem_rd_addr counts 0..K-1. After issuing address K-1 → FLUSH. With K=2**ADDR_W the last address is all-ones and the counter must not wrap early.
  - FLUSH: exactly 2N cycles (1 memory latency + 2(N-1) skew/propagation + 1 MAC register); mem_rd_en=0 → UNLOAD.
  - UNLOAD: out_valid=1, out_row starts at 0. Advance out_row only on out_valid&&out_ready. Acceptance of row N-1 → DONE.
  - DONE: done=1 for one cycle → IDLE.
- pe_en=1 in FEED and FLUSH only. Zeros pushed while feed_valid=0 keep the wavefront clean.
- feed_valid(t) = mem_rd_en(t-1), registered; it deasserts the cycle after FEED ends.
- start while busy: ignored, with no err pulse.
- out_row and out_valid must hold stable while out_ready=0. out_ready is ignored outside UNLOAD.
- Latency: with start at cycle 0 and out_ready tied high, done is high at cycle K+3N+2.

Optional Feature:
Macro: SYSTOLIC_PERF_CNT_EN.
- Defined:
  - Adds output perf_cycles (32 bits).
  - Counts cycles with busy=1 during the current operation, saturating at all-ones.
  - Updates to the final count in the DONE cycle and holds until the next DONE.
  - Resets to 0.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Package systolic_pkg holds:
  - N, DATA_W, ADDR_W defaults
  - the state enum (IDLE, CLEAR, FEED, FLUSH, UNLOAD, DONE)
  - localparam FLUSH_LEN = 2*N
- Single module with inline address, flush and row counters; no sub-module is warranted.

Test Plan:
- N=4, K=1, out_ready=1, start at cycle 0. Required response:
  - pe_clear at cycle 1
  - mem_rd_en cycle 2 with addr 0
  - feed_valid cycle 3
  - pe_en cycles 2..10
  - out_valid cycles 11..14 with out_row 0,1,2,3
  - done at cycle 15, busy cycles 1..15
- K=256 (k_len=9'h100): addresses 0..255 issued once each, no wrap, done at cycle 270.
- k_len=0 with start: err pulse at cycle 1; busy, mem_rd_en and done stay 0.
- K=4 with out_ready=0 for 3 cycles when out_row=2: out_row holds 2 with out_valid=1; done is delayed by exactly 3 cycles (cycle 21).
- rst asserted mid-FEED at addr 5: all outputs 0 asynchronously. A new start with K=2 after release completes normally (done 16 cycles after start).
- Second start pulses during FEED and UNLOAD: no effect on addresses, err or done count; exactly one done pulse.
